// File: rtl/atm_pkg.sv
// Shared encodings and sizes for the ATM PIN verification block.
package atm_pkg;
  localparam int PIN_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int PIN_W      = PIN_DIGITS * DIGIT_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_OK      = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKED  = 3'd5
  } state_t;
endpackage

// File: rtl/atm_inactivity_timer.sv
// Inactivity counter: counts enabled cycles, saturates at TIMEOUT_CYCLES-1.
module atm_inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  // Next count: clear wins, otherwise advance while enabled until expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/atm_pin_verify.sv
// PIN entry/verification FSM: collects four BCD digits, compares with the
// card PIN, counts wrong attempts and retains the card on lockout.
module atm_pin_verify
  import atm_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic             key_clear,
  input  logic             key_enter,
  input  logic [PIN_W-1:0] stored_pin,
  output logic             pin_ok,
  output logic             pin_fail,
  output logic             timeout,
  output logic             card_retain,
  output logic [1:0]       attempts_left,
  output logic [2:0]       digit_count,
  output logic [2:0]       state
);
  state_t             state_q, state_d;
  logic [PIN_W-1:0]   pin_buf_q, pin_buf_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [1:0]         att_q, att_d;
  logic               tmr_clear, tmr_en, tmr_expired, timeout_c;

  atm_inactivity_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  assign pin_ok        = (state_q == S_OK);
  assign pin_fail      = (state_q == S_FAIL);
  assign card_retain   = (state_q == S_LOCKED);
  assign timeout       = timeout_c;
  assign attempts_left = att_q;
  assign digit_count   = cnt_q;
  assign state         = state_q;

  // Next-state, datapath updates and timer control.
  always_comb begin
    state_d   = state_q;
    pin_buf_d = pin_buf_q;
    cnt_d     = cnt_q;
    att_d     = att_q;
    tmr_clear = 1'b1;
    tmr_en    = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COLLECT;
          pin_buf_d = '0;
          cnt_d     = '0;
          att_d     = 2'(MAX_ATTEMPTS);
        end
      end
      S_COLLECT: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (key_clear) begin
          pin_buf_d = '0;
          cnt_d     = '0;
        end else if (key_enter) begin
          // Short entries are dropped without costing an attempt.
          if (cnt_q == 3'(PIN_DIGITS)) state_d = S_CHECK;
        end else if (key_valid) begin
          // Invalid digits and overflow digits still count as activity.
          if (key_digit <= 4'd9 && cnt_q < 3'(PIN_DIGITS)) begin
            pin_buf_d = {pin_buf_q[PIN_W-DIGIT_W-1:0], key_digit};
            cnt_d     = cnt_q + 3'd1;
          end
        end else if (tmr_expired) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmr_clear = 1'b0;
          tmr_en    = 1'b1;
        end
      end
      S_CHECK: begin
        pin_buf_d = '0;
        cnt_d     = '0;
        if (!start) begin
          state_d = S_IDLE;
        end else if (pin_buf_q == stored_pin) begin
          state_d = S_OK;
        end else begin
          att_d   = att_q - 2'd1;
          state_d = (att_q == 2'd1) ? S_LOCKED : S_FAIL;
        end
      end
      S_OK: state_d = S_IDLE;
      S_FAIL: begin
        pin_buf_d = '0;
        cnt_d     = '0;
        state_d   = start ? S_COLLECT : S_IDLE;
      end
      S_LOCKED: state_d = S_LOCKED;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pin_buf_q <= '0;
      cnt_q     <= '0;
      att_q     <= 2'(MAX_ATTEMPTS);
    end else begin
      state_q   <= state_d;
      pin_buf_q <= pin_buf_d;
      cnt_q     <= cnt_d;
      att_q     <= att_d;
    end
  end
endmodule

// File: tb/tb_atm_pin_verify.sv
// Directed bench for atm_pin_verify with hand-computed expectations.
module tb_atm_pin_verify;
  logic        clk = 1'b0;
  logic        reset, start, key_valid, key_clear, key_enter;
  logic [3:0]  key_digit;
  logic [15:0] stored_pin;
  logic        pin_ok, pin_fail, timeout, card_retain;
  logic [1:0]  attempts_left;
  logic [2:0]  digit_count, state;
  int          n_chk = 0, n_err = 0;

  atm_pin_verify #(.MAX_ATTEMPTS(3), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .key_valid(key_valid),
    .key_digit(key_digit), .key_clear(key_clear), .key_enter(key_enter),
    .stored_pin(stored_pin), .pin_ok(pin_ok), .pin_fail(pin_fail),
    .timeout(timeout), .card_retain(card_retain),
    .attempts_left(attempts_left), .digit_count(digit_count), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    step();
    key_valid = 1'b0; key_digit = 4'd0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    step();
    key_enter = 1'b0;
  endtask

  task automatic pin4(input logic [15:0] p);
    key(p[15:12]); key(p[11:8]); key(p[7:4]); key(p[3:0]);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_valid = 1'b0; key_clear = 1'b0;
    key_enter = 1'b0; key_digit = 4'd0; stored_pin = 16'h1234;
    step(); step();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_cnt", 16'(digit_count), 16'd0);
    chk("rst_att", 16'(attempts_left), 16'd3);
    chk("rst_pulses", {13'd0, pin_ok, pin_fail, timeout}, 16'd0);
    chk("rst_retain", 16'(card_retain), 16'd0);

    // Correct PIN
    reset = 1'b0; start = 1'b1;
    step();
    chk("collect", 16'(state), 16'd1);
    pin4(16'h1234);
    chk("cnt4", 16'(digit_count), 16'd4);
    enter();
    chk("check_st", 16'(state), 16'd2);
    chk("check_ok0", 16'(pin_ok), 16'd0);
    step();
    chk("ok_st", 16'(state), 16'd3);
    chk("ok_pulse", 16'(pin_ok), 16'd1);
    step();
    chk("ok_done", 16'(pin_ok), 16'd0);
    chk("ok_idle", 16'(state), 16'd0);
    step();

    // Short entry ignored, then clear and correct entry
    key(4'd1); key(4'd2);
    enter();
    chk("short_st", 16'(state), 16'd1);
    chk("short_att", 16'(attempts_left), 16'd3);
    chk("short_cnt", 16'(digit_count), 16'd2);
    key_clear = 1'b1; step(); key_clear = 1'b0;
    chk("clr_cnt", 16'(digit_count), 16'd0);
    pin4(16'h1234);
    enter(); step();
    chk("clr_ok", 16'(pin_ok), 16'd1);
    step(); step();

    // Fifth digit and invalid digit ignored; buffer still 1234
    pin4(16'h1234); key(4'd9); key(4'hA);
    chk("ovf_cnt", 16'(digit_count), 16'd4);
    enter(); step();
    chk("ovf_ok", 16'(pin_ok), 16'd1);
    step(); step();

    // Same-cycle clear/enter/digit: clear wins
    pin4(16'h1234);
    key_clear = 1'b1; key_enter = 1'b1; key_valid = 1'b1; key_digit = 4'd5;
    step();
    key_clear = 1'b0; key_enter = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    chk("prio_st", 16'(state), 16'd1);
    chk("prio_cnt", 16'(digit_count), 16'd0);

    // Three wrong entries lead to lockout
    for (int i = 0; i < 2; i++) begin
      pin4(16'h1235); enter(); step();
      chk("fail_st", 16'(state), 16'd4);
      chk("fail_pulse", 16'(pin_fail), 16'd1);
      chk("fail_att", 16'(attempts_left), 16'(2 - i));
      step();
      chk("fail_back", 16'(state), 16'd1);
      chk("fail_cnt", 16'(digit_count), 16'd0);
    end
    pin4(16'h1235); enter(); step();
    chk("lock_st", 16'(state), 16'd5);
    chk("lock_retain", 16'(card_retain), 16'd1);
    chk("lock_nofail", 16'(pin_fail), 16'd0);
    chk("lock_att", 16'(attempts_left), 16'd0);
    start = 1'b0; step(); step();
    chk("lock_hold", 16'(state), 16'd5);

    // Reset releases lockout
    reset = 1'b1; step(); reset = 1'b0;
    chk("unlock_retain", 16'(card_retain), 16'd0);
    chk("unlock_st", 16'(state), 16'd0);
    chk("unlock_att", 16'(attempts_left), 16'd3);

    // Inactivity timeout: pulse in the 16th COLLECT cycle
    start = 1'b1; step();
    for (int i = 0; i < 14; i++) step();
    chk("to_early", 16'(timeout), 16'd0);
    step();
    chk("to_pulse", 16'(timeout), 16'd1);
    chk("to_st", 16'(state), 16'd1);
    step();
    chk("to_idle", 16'(state), 16'd0);
    chk("to_done", 16'(timeout), 16'd0);

    // Start dropping aborts the session silently
    step(); key(4'd7);
    start = 1'b0; step();
    chk("abort_st", 16'(state), 16'd0);
    chk("abort_pulses", {13'd0, pin_ok, pin_fail, timeout}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
